game_controller: RTL and testbench
==================================

# game_controller

Top-level game sequencer for the runner. It owns the game state machine (idle, running, paused, hit, game over) and generates the `clk50` movement tick, the `pause` level and the `person_reset` pulse that drive the player sprite block. It detects player/obstacle collisions from the per-pixel `person_on` / `obstacle_on` flags, evaluates them once per frame, and maintains the lives and score counters consumed by the HUD.

## Interface
- `TICK_DIV`, 2_000_000: `clk` cycles per `clk50` tick (50 Hz at 100 MHz).
- `LIVES`, 3: lives at game start; range 1..3.
- `HIT_TICKS`, 100: invulnerability length in `clk50` ticks; range 1..255.
- `clk` in 1: system clock, 100 MHz.
- `reset_game` in 1: synchronous, active-high reset.
- `btn_start` in 1: debounced level; a rising edge starts or restarts the game.
- `btn_pause` in 1: debounced level; a rising edge toggles pause.
- `pixel_x` in 10: current scan column.
- `pixel_y` in 10: current scan row.
- `person_on` in 1: player sprite pixel active.
- `obstacle_on` in 1: obstacle pixel active.
- `clk50` out 1: one-cycle movement tick.
- `pause` out 1: freezes sprite motion.
- `person_reset` out 1: one-cycle pulse that recentres the player.
- `state` out 3: IDLE=0, RUN=1, PAUSED=2, HIT=3, OVER=4.
- `lives` out 2: remaining lives.
- `score` out 16: score in ticks survived.
- `game_over` out 1: high while in OVER.

## Operation
- **Tick divider**
  - Free-running counter 0..TICK_DIV-1; it wraps to 0.
  - `clk50` is registered and is high for exactly the one cycle in which the counter equals TICK_DIV-1.
  - The divider runs in every state; only `reset_game` clears it.
- **Edge detect**
  - `btn_start` and `btn_pause` are each registered once.
  - A rise is `btn & !btn_q`, which gives one pulse per press.
- **Frame end**
  - `frame_end` is a single-cycle pulse on the first cycle in which (`pixel_x`==0 && `pixel_y`==480).
  - The compare result is registered and edge-detected, so a coordinate held for several `clk` cycles still yields one pulse.
- **Collision latch**
  - Set when `person_on & obstacle_on` in state RUN.
  - Cleared on every `frame_end` and on every state transition.
  - Never set in IDLE, PAUSED, HIT or OVER.
- **FSM**
  - IDLE: `pause`=1.
    - Start rise → RUN, `person_reset` pulse, `lives`=LIVES, `score`=0, collision latch cleared.
  - RUN: `pause`=0.
    - On each `clk50`, `score`+1, saturating at 16'hFFFF.
    - `frame_end` with latch set: `lives`-1. If `lives` was 1 → OVER (`lives`=0); otherwise → HIT with `hit_cnt`=HIT_TICKS.
    - Otherwise a pause rise → PAUSED.
    - Start rise is ignored.
  - PAUSED: `pause`=1; `score` is frozen.
    - Pause rise → RUN. Start rise is ignored.
  - HIT: `pause`=0; `score` keeps counting; collisions are ignored.
    - `hit_cnt` decrements on each `clk50`.
    - When it decrements from 1 to 0 → RUN.
    - Pause and start rises are ignored.
  - OVER: `pause`=1, `game_over`=1; `score` and `lives` hold.
    - Start rise → RUN with the same initialisation as from IDLE.
- **Priority in RUN:** reset_game > collision at frame_end > pause rise.

## Timing
- **Reset values** (cycle after `reset_game` is sampled high):
  - `state`=IDLE, `lives`=LIVES, `score`=0, `clk50`=0, `pause`=1, `game_over`=0.
  - Divider, `hit_cnt`, collision latch and edge registers all 0.
  - `person_reset`=1 for that single cycle, then 0.
- **Reset mid-operation:** `reset_game` overrides any state, including during HIT or PAUSED, with the same values.
- **Output registering:** all outputs are registered.
- **Button latency:**
  - cycle N: button first sampled high;
  - cycle N+1: rise is valid;
  - cycle N+2: `state` and `pause` updated.
  - `person_reset` is high in the same cycle that `state` becomes RUN.
- **Collision latency:** `state` and `lives` update one cycle after `frame_end`.
- **Start from IDLE:** a `clk50` coincident with the start transition does not increment `score`; `score` is exactly 0 on entering RUN.

## Test plan
- **Reset and start.** Assert `reset_game` 1 cycle, then pulse `btn_start`.
  - Required: `state`=0, `pause`=1, `lives`=3, `person_reset` high 1 cycle after reset.
  - Required: after start, `state`=1, `pause`=0, second `person_reset` pulse, `score`=0.
- **Tick and score.** Set TICK_DIV=4 and run 40 cycles in RUN.
  - Required: `clk50` high every 4th cycle, and `score`=10.
  - Hold `score` at 16'hFFFE and apply 3 ticks → `score`=16'hFFFF.
- **Pause toggle.** Pulse `btn_pause` in RUN, hold it high 50 cycles, release, then pulse again.
  - Required: single PAUSED entry, `score` constant while paused, return to RUN.
  - Required: a start rise while PAUSED leaves `state`=2.
- **Collision to hit and back.**
  - Setup: assert `person_on` & `obstacle_on` for 1 cycle mid-frame, then drive `pixel_x`=0, `pixel_y`=480 for 4 cycles.
  - Required: exactly one decrement, `lives`=2, `state`=3.
  - Required: with HIT_TICKS=5, `state`=1 after the 5th `clk50`.
  - Required: a collision during HIT does not decrement.
- **Game over and restart.** Three collision frames with LIVES=3.
  - Required: `lives`=0, `state`=4, `game_over`=1, `pause`=1.
  - Required: start rise → RUN, `lives`=3, `score`=0.
- **Simultaneous events.**
  - Pause rise in the same cycle as a `frame_end` with collision → HIT, not PAUSED.
  - `reset_game` during HIT → IDLE with reset values.

Source files
------------

// File: rtl/game_controller_if.sv
// Status and control bundle between the game sequencer and the sprite/HUD/input side.
// master drives buttons and pixel flags, slave (the sequencer) drives tick, pause and counters.
interface game_controller_if;
    logic        btn_start;
    logic        btn_pause;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        person_on;
    logic        obstacle_on;
    logic        clk50;
    logic        pause;
    logic        person_reset;
    logic [2:0]  state;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;

    modport master (
        output btn_start, btn_pause, pixel_x, pixel_y, person_on, obstacle_on,
        input  clk50, pause, person_reset, state, lives, score, game_over
    );

    modport slave (
        input  btn_start, btn_pause, pixel_x, pixel_y, person_on, obstacle_on,
        output clk50, pause, person_reset, state, lives, score, game_over
    );
endinterface

// File: rtl/game_controller.sv
// Runner game sequencer: tick divider, button edges, per-frame collision check, lives/score.
// Buttons act two cycles after first sampled high, collisions one cycle after frame end; no backpressure.
module game_controller #(
    parameter int TICK_DIV  = 2_000_000,
    parameter int LIVES     = 3,
    parameter int HIT_TICKS = 100
) (
    input  logic             clk,
    input  logic             reset_game,
    game_controller_if.slave gc
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSED = 3'd2,
        S_HIT    = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam int            DW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX    = DW'(TICK_DIV - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [7:0]    HIT_INIT   = 8'(HIT_TICKS);

    state_t        state_q;
    logic [DW-1:0] div_q, div_d;
    logic          clk50_q, pause_q, person_reset_q, game_over_q;
    logic [1:0]    lives_q;
    logic [15:0]   score_q, score_inc;
    logic [7:0]    hit_cnt_q;
    logic          start_q, pbtn_q, start_rise_q, pause_rise_q;
    logic          fe_cmp_q, fe_prev_q, frame_end, coll_q;

    assign div_d     = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
    assign score_inc = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
    assign frame_end = fe_cmp_q & ~fe_prev_q;

    always_ff @(posedge clk) begin
        if (reset_game) begin
            div_q          <= '0;
            clk50_q        <= 1'b0;
            start_q        <= 1'b0;
            pbtn_q         <= 1'b0;
            start_rise_q   <= 1'b0;
            pause_rise_q   <= 1'b0;
            fe_cmp_q       <= 1'b0;
            fe_prev_q      <= 1'b0;
            coll_q         <= 1'b0;
            hit_cnt_q      <= 8'd0;
            state_q        <= S_IDLE;
            lives_q        <= LIVES_INIT;
            score_q        <= 16'd0;
            pause_q        <= 1'b1;
            game_over_q    <= 1'b0;
            person_reset_q <= 1'b1;
        end else begin
            // clk50 is aligned with the cycle in which the divider sits at its last count
            div_q          <= div_d;
            clk50_q        <= (div_d == DIV_MAX);
            start_q        <= gc.btn_start;
            pbtn_q         <= gc.btn_pause;
            start_rise_q   <= gc.btn_start & ~start_q;
            pause_rise_q   <= gc.btn_pause & ~pbtn_q;
            fe_cmp_q       <= (gc.pixel_x == 10'd0) && (gc.pixel_y == 10'd480);
            fe_prev_q      <= fe_cmp_q;
            person_reset_q <= 1'b0;

            if (frame_end)
                coll_q <= 1'b0;
            else if (state_q == S_RUN && gc.person_on && gc.obstacle_on)
                coll_q <= 1'b1;

            // every transition below also clears the collision latch (last assignment wins)
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_rise_q) begin
                        state_q        <= S_RUN;
                        pause_q        <= 1'b0;
                        game_over_q    <= 1'b0;
                        person_reset_q <= 1'b1;
                        lives_q        <= LIVES_INIT;
                        score_q        <= 16'd0;
                        coll_q         <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (clk50_q)
                        score_q <= score_inc;
                    if (frame_end && coll_q) begin
                        coll_q <= 1'b0;
                        if (lives_q == 2'd1) begin
                            lives_q     <= 2'd0;
                            state_q     <= S_OVER;
                            pause_q     <= 1'b1;
                            game_over_q <= 1'b1;
                        end else begin
                            lives_q   <= lives_q - 2'd1;
                            state_q   <= S_HIT;
                            hit_cnt_q <= HIT_INIT;
                        end
                    end else if (pause_rise_q) begin
                        state_q <= S_PAUSED;
                        pause_q <= 1'b1;
                        coll_q  <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (pause_rise_q) begin
                        state_q <= S_RUN;
                        pause_q <= 1'b0;
                        coll_q  <= 1'b0;
                    end
                end
                S_HIT: begin
                    if (clk50_q) begin
                        score_q   <= score_inc;
                        hit_cnt_q <= hit_cnt_q - 8'd1;
                        if (hit_cnt_q == 8'd1) begin
                            state_q <= S_RUN;
                            coll_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gc.clk50        = clk50_q;
    assign gc.pause        = pause_q;
    assign gc.person_reset = person_reset_q;
    assign gc.state        = state_q;
    assign gc.lives        = lives_q;
    assign gc.score        = score_q;
    assign gc.game_over    = game_over_q;
endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: button vector table with an expectation queue,
// plus sequences for tick/score, pause hold, collisions, game over, simultaneous events and saturation.
module tb_game_controller;
    logic clk;
    logic reset_game;

    game_controller_if gif();
    game_controller_if gif2();

    game_controller #(.TICK_DIV(4), .LIVES(3), .HIT_TICKS(5)) dut (
        .clk        (clk),
        .reset_game (reset_game),
        .gc         (gif.slave)
    );

    game_controller #(.TICK_DIV(1), .LIVES(3), .HIT_TICKS(5)) dut_sat (
        .clk        (clk),
        .reset_game (reset_game),
        .gc         (gif2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef enum logic {OP_START, OP_PAUSE} op_e;
    typedef struct {
        op_e        op;
        logic [2:0] st;
        logic [1:0] lives;
        logic       pause;
    } vec_t;
    typedef struct {
        int         idx;
        logic [2:0] st;
        logic [1:0] lives;
        logic       pause;
    } exp_t;

    vec_t vecs[5];
    exp_t exp_q[$];

    // Counts clk50 ticks seen while in HIT; a HIT->RUN exit must follow exactly the 5th tick.
    logic [2:0] prev_state = 3'd0;
    int         hit_ticks  = 0;
    always @(negedge clk) begin
        if (gif.state == 3'd3) begin
            if (prev_state != 3'd3)
                hit_ticks = 0;
            if (gif.clk50)
                hit_ticks++;
        end else if (prev_state == 3'd3 && gif.state == 3'd1) begin
            check("hit_exit_ticks", hit_ticks, 5);
        end
        prev_state = gif.state;
    end

    task automatic press(input bit is_pause);
        if (is_pause) gif.btn_pause = 1'b1;
        else          gif.btn_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_btns();
        gif.btn_start = 1'b0;
        gif.btn_pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic collide_frame();
        gif.person_on   = 1'b1;
        gif.obstacle_on = 1'b1;
        @(negedge clk);
        gif.person_on   = 1'b0;
        gif.obstacle_on = 1'b0;
        gif.pixel_x     = 10'd0;
        gif.pixel_y     = 10'd480;
        repeat (4) @(negedge clk);
        gif.pixel_x     = 10'd100;
        gif.pixel_y     = 10'd100;
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        int k;
        k = 0;
        while (gif.state != st && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, gif.state, st);
    endtask

    initial begin
        int s0, ticks, last, k;

        gif.btn_start = 0; gif.btn_pause = 0; gif.person_on = 0; gif.obstacle_on = 0;
        gif.pixel_x = 10'd100; gif.pixel_y = 10'd100;
        gif2.btn_start = 0; gif2.btn_pause = 0; gif2.person_on = 0; gif2.obstacle_on = 0;
        gif2.pixel_x = 10'd100; gif2.pixel_y = 10'd100;

        vecs[0] = '{OP_START, 3'd1, 2'd3, 1'b0};
        vecs[1] = '{OP_START, 3'd1, 2'd3, 1'b0};
        vecs[2] = '{OP_PAUSE, 3'd2, 2'd3, 1'b1};
        vecs[3] = '{OP_START, 3'd2, 2'd3, 1'b1};
        vecs[4] = '{OP_PAUSE, 3'd1, 2'd3, 1'b0};

        reset_game = 1'b1;
        @(negedge clk);
        check("rst_state", gif.state, 0);
        check("rst_pause", gif.pause, 1);
        check("rst_lives", gif.lives, 3);
        check("rst_score", gif.score, 0);
        check("rst_clk50", gif.clk50, 0);
        check("rst_game_over", gif.game_over, 0);
        check("rst_person_reset", gif.person_reset, 1);
        reset_game = 1'b0;
        @(negedge clk);
        check("rst_person_reset_drop", gif.person_reset, 0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            exp_t e, g;
            e.idx = i; e.st = vecs[i].st; e.lives = vecs[i].lives; e.pause = vecs[i].pause;
            exp_q.push_back(e);
            press(vecs[i].op == OP_PAUSE);
            g = exp_q.pop_front();
            check($sformatf("vec%0d_state", g.idx), gif.state, g.st);
            check($sformatf("vec%0d_lives", g.idx), gif.lives, g.lives);
            check($sformatf("vec%0d_pause", g.idx), gif.pause, g.pause);
            if (i == 0) begin
                check("start_person_reset", gif.person_reset, 1);
                check("start_score", gif.score, 0);
            end
            release_btns();
        end

        s0 = gif.score; ticks = 0; last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gif.clk50) begin
                if (last >= 0) check("clk50_period", c - last, 4);
                last = c;
                ticks++;
            end
        end
        check("clk50_count", ticks, 10);
        check("score_40cyc", gif.score, s0 + 10);

        gif.btn_pause = 1'b1;
        @(negedge clk); @(negedge clk);
        check("pause_enter", gif.state, 2);
        s0 = gif.score;
        repeat (48) @(negedge clk);
        check("pause_held_state", gif.state, 2);
        check("pause_score_frozen", gif.score, s0);
        gif.btn_pause = 1'b0;
        @(negedge clk);
        press(1'b1);
        check("pause_exit", gif.state, 1);
        release_btns();

        collide_frame();
        check("hit_state", gif.state, 3);
        check("hit_lives", gif.lives, 2);
        check("hit_pause", gif.pause, 0);
        collide_frame();
        check("hit_ignore_state", gif.state, 3);
        check("hit_ignore_lives", gif.lives, 2);
        wait_state(3'd1, "hit_return_run");

        collide_frame();
        check("hit2_lives", gif.lives, 1);
        wait_state(3'd1, "hit2_return_run");
        collide_frame();
        check("over_state", gif.state, 4);
        check("over_lives", gif.lives, 0);
        check("over_game_over", gif.game_over, 1);
        check("over_pause", gif.pause, 1);
        s0 = gif.score;
        repeat (10) @(negedge clk);
        check("over_score_hold", gif.score, s0);
        press(1'b0);
        check("restart_state", gif.state, 1);
        check("restart_lives", gif.lives, 3);
        check("restart_score", gif.score, 0);
        check("restart_person_reset", gif.person_reset, 1);
        check("restart_game_over", gif.game_over, 0);
        release_btns();

        gif.person_on = 1'b1; gif.obstacle_on = 1'b1;
        @(negedge clk);
        gif.person_on = 1'b0; gif.obstacle_on = 1'b0;
        gif.pixel_x = 10'd0; gif.pixel_y = 10'd480; gif.btn_pause = 1'b1;
        @(negedge clk); @(negedge clk);
        check("simul_state", gif.state, 3);
        check("simul_lives", gif.lives, 2);
        gif.pixel_x = 10'd100; gif.pixel_y = 10'd100;
        release_btns();
        check("simul_still_hit", gif.state, 3);

        reset_game = 1'b1;
        @(negedge clk);
        check("midrst_state", gif.state, 0);
        check("midrst_lives", gif.lives, 3);
        check("midrst_score", gif.score, 0);
        check("midrst_pause", gif.pause, 1);
        check("midrst_clk50", gif.clk50, 0);
        check("midrst_person_reset", gif.person_reset, 1);
        reset_game = 1'b0;
        @(negedge clk);
        check("midrst_person_reset_drop", gif.person_reset, 0);
        check("midrst_idle", gif.state, 0);

        gif2.btn_start = 1'b1;
        @(negedge clk); @(negedge clk);
        check("sat_start_state", gif2.state, 1);
        check("sat_start_score", gif2.score, 0);
        gif2.btn_start = 1'b0;
        k = 0;
        while (gif2.score != 16'hFFFE && k < 70000) begin
            @(negedge clk);
            k++;
        end
        check("sat_reach_fffe", gif2.score, 16'hFFFE);
        repeat (3) @(negedge clk);
        check("sat_score", gif2.score, 16'hFFFF);
        check("sat_state", gif2.state, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
